// File: rtl/spi_slave_cmd_seq_if.sv
// rtl/spi_slave_cmd_seq_if.sv - command, plug and status signals of the SPI-slave command sequencer
interface spi_slave_cmd_seq_if #(
    parameter int LEN_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;
    logic             up_rx_valid;
    logic             up_rx_ready;
    logic             plug_rx_valid;
    logic             plug_rx_ready;
    logic             plug_tx_valid;
    logic             plug_tx_ready;
    logic [31:0]      rxtx_addr;
    logic             rxtx_addr_valid;
    logic             start_tx;
    logic             busy;
    logic [LEN_W-1:0] words_left;
    logic             done;
    logic [1:0]       status;

    // Sequencer side
    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  up_rx_valid, plug_rx_ready, plug_tx_valid, plug_tx_ready,
        output cmd_ready, up_rx_ready, plug_rx_valid,
        output rxtx_addr, rxtx_addr_valid, start_tx,
        output busy, words_left, done, status
    );

    // Command source / plug side
    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output up_rx_valid, plug_rx_ready, plug_tx_valid, plug_tx_ready,
        input  cmd_ready, up_rx_ready, plug_rx_valid,
        input  rxtx_addr, rxtx_addr_valid, start_tx,
        input  busy, words_left, done, status
    );
endinterface

// File: rtl/spi_slave_cmd_seq.sv
// rtl/spi_slave_cmd_seq.sv - sequences one SPI command through the AXI plug and reports completion status
module spi_slave_cmd_seq #(
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic               axi_aclk,
    input  logic               axi_areset,
    input  logic               cs,
    spi_slave_cmd_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_RD_START = 3'd2;
    localparam logic [2:0] S_WR       = 3'd3;
    localparam logic [2:0] S_RD       = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_CS      = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

    // Counter only needs to reach TIMEOUT_CYCLES-1; a zero setting disables expiry.
    localparam int              TO_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LEN_W-1:0] ONE_WORD = LEN_W'(1);

    logic [2:0]       state;
    logic [2:0]       state_nx;
    logic [1:0]       status_q;
    logic [1:0]       status_nx;
    logic             wr_q;
    logic [31:0]      addr_q;
    logic [LEN_W-1:0] words_left_q;
    logic [TO_W-1:0]  to_cnt;

    logic             wr_hs;
    logic             rd_hs;
    logic             word_hs;
    logic             last_hs;
    logic             to_hit;
    logic             in_wait;

    assign wr_hs   = bus.plug_rx_valid & bus.plug_rx_ready;
    assign rd_hs   = bus.plug_tx_valid & bus.plug_tx_ready;
    // Only handshakes in the matching data state count; read prefetch elsewhere is ignored.
    assign word_hs = ((state == S_WR) & wr_hs) | ((state == S_RD) & rd_hs);
    assign last_hs = word_hs & (words_left_q == ONE_WORD);
    assign to_hit  = TO_EN & (to_cnt == TO_LAST);
    assign in_wait = (state == S_WR) | (state == S_RD) | (state == S_RD_START);

    assign bus.cmd_ready       = (state == S_IDLE);
    assign bus.busy            = (state != S_IDLE);
    assign bus.rxtx_addr       = addr_q;
    assign bus.rxtx_addr_valid = (state == S_LOAD);
    assign bus.start_tx        = (state == S_RD_START) & ~cs;
    assign bus.plug_rx_valid   = (state == S_WR) & bus.up_rx_valid;
    assign bus.up_rx_ready     = (state == S_WR) & bus.plug_rx_ready;
    assign bus.words_left      = words_left_q;
    assign bus.done            = (state == S_DONE);
    assign bus.status          = status_q;

    // Next state and completion status; a counted last word beats cs, and any handshake beats timeout.
    always_comb begin
        state_nx  = state;
        status_nx = ST_OK;
        case (state)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    if (bus.cmd_len == '0) begin
                        state_nx  = S_DONE;
                        status_nx = ST_OK;
                    end else begin
                        state_nx = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_nx = wr_q ? S_WR : S_RD_START;
            end
            S_RD_START: begin
                if (!cs) begin
                    state_nx = S_RD;
                end else if (to_hit) begin
                    state_nx  = S_DONE;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_WR, S_RD: begin
                if (last_hs) begin
                    state_nx  = S_DONE;
                    status_nx = ST_OK;
                end else if (cs) begin
                    state_nx  = S_DONE;
                    status_nx = ST_CS;
                end else if (!word_hs && to_hit) begin
                    state_nx  = S_DONE;
                    status_nx = ST_TIMEOUT;
                end
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register and the status code, which only changes on entry to DONE.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            state    <= S_IDLE;
            status_q <= ST_OK;
        end else begin
            state <= state_nx;
            if (state_nx == S_DONE) begin
                status_q <= status_nx;
            end
        end
    end

    // Command latch and remaining-word counter.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            wr_q         <= 1'b0;
            addr_q       <= '0;
            words_left_q <= '0;
        end else begin
            if ((state == S_IDLE) && bus.cmd_valid) begin
                wr_q   <= bus.cmd_write;
                addr_q <= bus.cmd_addr;
                if (bus.cmd_len != '0) begin
                    words_left_q <= bus.cmd_len;
                end
            end else if (word_hs) begin
                words_left_q <= words_left_q - 1'b1;
            end
        end
    end

    // No-progress counter: runs while staying in a wait state, clears on entry and on each counted word.
    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            to_cnt <= '0;
        end else if (TO_EN && in_wait && (state_nx == state) && !word_hs) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end
endmodule

// File: tb/tb_spi_slave_cmd_seq.sv
// tb/tb_spi_slave_cmd_seq.sv - directed self-checking bench for spi_slave_cmd_seq
module tb_spi_slave_cmd_seq;
    localparam int LEN_W = 8;
    localparam int TO    = 16;

    logic axi_aclk   = 1'b0;
    logic axi_areset = 1'b1;
    logic cs         = 1'b1;

    spi_slave_cmd_seq_if #(.LEN_W(LEN_W)) bus ();

    spi_slave_cmd_seq #(
        .LEN_W          (LEN_W),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .axi_aclk   (axi_aclk),
        .axi_areset (axi_areset),
        .cs         (cs),
        .bus        (bus)
    );

    always #5 axi_aclk = ~axi_aclk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic nxt();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic smp();
        @(negedge axi_aclk);
    endtask

    task automatic offer(input logic wr, input logic [31:0] a, input logic [LEN_W-1:0] l);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_len   = l;
    endtask

    logic [31:0] hs;
    logic [31:0] first;
    logic [31:0] st;
    logic [31:0] seen;

    initial begin
        bus.cmd_valid     = 1'b0;
        bus.cmd_write     = 1'b0;
        bus.cmd_addr      = '0;
        bus.cmd_len       = '0;
        bus.up_rx_valid   = 1'b0;
        bus.plug_rx_ready = 1'b0;
        bus.plug_tx_valid = 1'b0;
        bus.plug_tx_ready = 1'b0;

        nxt();
        nxt();
        axi_areset = 1'b0;
        smp();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_words_left", 32'(bus.words_left), 0);
        chk("rst_addr", bus.rxtx_addr, 0);
        chk("rst_status", 32'(bus.status), 0);
        chk("rst_addr_valid", 32'(bus.rxtx_addr_valid), 0);
        nxt();

        // Test 1: write, len 3, continuous handshakes
        cs = 1'b0;
        bus.up_rx_valid   = 1'b1;
        bus.plug_rx_ready = 1'b1;
        offer(1'b1, 32'h1000_0000, 8'd3);
        smp();
        chk("t1_cmd_ready", 32'(bus.cmd_ready), 1);
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("t1_addr_valid", 32'(bus.rxtx_addr_valid), 1);
        chk("t1_addr", bus.rxtx_addr, 32'h1000_0000);
        chk("t1_no_rx_in_load", 32'(bus.plug_rx_valid), 0);
        hs = 0;
        for (int i = 0; i < 3; i++) begin
            nxt();
            smp();
            chk("t1_words_left", 32'(bus.words_left), 32'(3 - i));
            chk("t1_done_low", 32'(bus.done), 0);
            if (bus.plug_rx_valid && bus.plug_rx_ready) hs = hs + 1;
        end
        nxt();
        smp();
        chk("t1_done", 32'(bus.done), 1);
        chk("t1_status", 32'(bus.status), 0);
        chk("t1_rx_valid_off", 32'(bus.plug_rx_valid), 0);
        chk("t1_words_left_end", 32'(bus.words_left), 0);
        chk("t1_hs_count", hs, 3);
        nxt();
        smp();
        chk("t1_cmd_ready_back", 32'(bus.cmd_ready), 1);
        chk("t1_done_once", 32'(bus.done), 0);
        nxt();

        // Test 2: read, len 2, extra prefetch word ignored; write words blocked during read
        bus.plug_tx_ready = 1'b1;
        offer(1'b0, 32'h2000_0040, 8'd2);
        smp();
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("t2_addr_valid", 32'(bus.rxtx_addr_valid), 1);
        chk("t2_start_early", 32'(bus.start_tx), 0);
        nxt();
        smp();
        chk("t2_start_tx", 32'(bus.start_tx), 1);
        nxt();
        bus.plug_tx_valid = 1'b1;
        smp();
        chk("t2_start_once", 32'(bus.start_tx), 0);
        chk("t2_words_left", 32'(bus.words_left), 2);
        chk("t2_rx_blocked", 32'(bus.plug_rx_valid), 0);
        chk("t2_pop_blocked", 32'(bus.up_rx_ready), 0);
        nxt();
        smp();
        chk("t2_words_left2", 32'(bus.words_left), 1);
        chk("t2_not_done", 32'(bus.done), 0);
        nxt();
        smp();
        chk("t2_done", 32'(bus.done), 1);
        chk("t2_status", 32'(bus.status), 0);
        nxt();
        smp();
        chk("t2_prefetch_ignored", 32'(bus.words_left), 0);
        chk("t2_idle", 32'(bus.busy), 0);
        nxt();
        bus.plug_tx_valid = 1'b0;
        bus.up_rx_valid   = 1'b0;

        // Test 3a: write len 4, cs rises after 2 words
        offer(1'b1, 32'h3000_0000, 8'd4);
        smp();
        nxt();
        bus.cmd_valid   = 1'b0;
        bus.up_rx_valid = 1'b1;
        nxt();
        nxt();
        nxt();
        bus.up_rx_valid = 1'b0;
        cs = 1'b1;
        smp();
        chk("t3a_words_left", 32'(bus.words_left), 2);
        chk("t3a_not_done", 32'(bus.done), 0);
        nxt();
        smp();
        chk("t3a_done", 32'(bus.done), 1);
        chk("t3a_status", 32'(bus.status), 1);
        chk("t3a_words_left_end", 32'(bus.words_left), 2);
        nxt();
        cs = 1'b0;
        nxt();

        // Test 3b: cs rises together with the 4th handshake
        offer(1'b1, 32'h3000_0100, 8'd4);
        smp();
        nxt();
        bus.cmd_valid   = 1'b0;
        bus.up_rx_valid = 1'b1;
        nxt();
        nxt();
        nxt();
        nxt();
        cs = 1'b1;
        smp();
        chk("t3b_last_word", 32'(bus.words_left), 1);
        chk("t3b_last_hs", 32'(bus.plug_rx_valid & bus.plug_rx_ready), 1);
        nxt();
        bus.up_rx_valid = 1'b0;
        smp();
        chk("t3b_done", 32'(bus.done), 1);
        chk("t3b_status", 32'(bus.status), 0);
        chk("t3b_words_left", 32'(bus.words_left), 0);
        nxt();
        cs = 1'b0;
        nxt();

        // Test 4a: read len 1, no data, timeout after 16 cycles in RD
        offer(1'b0, 32'h4000_0000, 8'd1);
        smp();
        nxt();
        bus.cmd_valid = 1'b0;
        nxt();
        smp();
        chk("t4a_start", 32'(bus.start_tx), 1);
        nxt();
        first = 99;
        st    = 32'hff;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (bus.done && first == 99) begin
                first = 32'(k);
                st    = 32'(bus.status);
            end
            nxt();
        end
        chk("t4a_timeout_cycle", first, 16);
        chk("t4a_status", st, 2);

        // Test 5: zero-length command completes at once, no plug activity
        bus.up_rx_valid = 1'b1;
        seen = 0;
        offer(1'b1, 32'h5000_0000, 8'd0);
        smp();
        seen = seen | 32'(bus.rxtx_addr_valid | bus.start_tx | bus.plug_rx_valid);
        chk("t5_cmd_ready", 32'(bus.cmd_ready), 1);
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        seen = seen | 32'(bus.rxtx_addr_valid | bus.start_tx | bus.plug_rx_valid);
        chk("t5_done", 32'(bus.done), 1);
        chk("t5_status", 32'(bus.status), 0);
        nxt();
        smp();
        seen = seen | 32'(bus.rxtx_addr_valid | bus.start_tx | bus.plug_rx_valid);
        chk("t5_cmd_ready_back", 32'(bus.cmd_ready), 1);
        nxt();
        smp();
        seen = seen | 32'(bus.rxtx_addr_valid | bus.start_tx | bus.plug_rx_valid);
        chk("t5_no_plug_activity", seen, 0);
        nxt();
        bus.up_rx_valid = 1'b0;

        // Test 4b: handshake exactly on the expiry cycle wins over timeout
        offer(1'b0, 32'h4000_0100, 8'd1);
        smp();
        nxt();
        bus.cmd_valid = 1'b0;
        nxt();
        nxt();
        first = 99;
        st    = 32'hff;
        for (int k = 0; k < 20; k++) begin
            bus.plug_tx_valid = (k == 15);
            smp();
            if (bus.done && first == 99) begin
                first = 32'(k);
                st    = 32'(bus.status);
            end
            nxt();
        end
        bus.plug_tx_valid = 1'b0;
        chk("t4b_done_cycle", first, 16);
        chk("t4b_status", st, 0);

        // Test 6: reset mid-write, then a fresh command
        bus.up_rx_valid = 1'b1;
        offer(1'b1, 32'h6000_0000, 8'd3);
        smp();
        nxt();
        bus.cmd_valid = 1'b0;
        nxt();
        nxt();
        axi_areset = 1'b1;
        smp();
        chk("t6_mid_words_left", 32'(bus.words_left), 2);
        nxt();
        axi_areset = 1'b0;
        smp();
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_cmd_ready", 32'(bus.cmd_ready), 1);
        chk("t6_rx_valid", 32'(bus.plug_rx_valid), 0);
        chk("t6_words_left", 32'(bus.words_left), 0);
        chk("t6_no_done", 32'(bus.done), 0);
        nxt();
        smp();
        chk("t6_no_done_later", 32'(bus.done), 0);
        nxt();
        bus.up_rx_valid = 1'b0;
        offer(1'b0, 32'h6000_0100, 8'd1);
        smp();
        chk("t6_new_accept", 32'(bus.cmd_ready), 1);
        nxt();
        bus.cmd_valid = 1'b0;
        smp();
        chk("t6_new_addr_valid", 32'(bus.rxtx_addr_valid), 1);
        chk("t6_new_addr", bus.rxtx_addr, 32'h6000_0100);
        nxt();
        smp();
        chk("t6_new_start", 32'(bus.start_tx), 1);
        nxt();
        bus.plug_tx_valid = 1'b1;
        smp();
        nxt();
        bus.plug_tx_valid = 1'b0;
        smp();
        chk("t6_new_done", 32'(bus.done), 1);
        chk("t6_new_status", 32'(bus.status), 0);
        chk("t6_new_words_left", 32'(bus.words_left), 0);
        nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
